superscalar_regfile_sb: RTL and testbench
=========================================

// Module: superscalar_regfile_sb
// PURPOSE
//  Parametrised multi-port integer register file for the N-way superscalar core, with
//  clocked writes, x0 hardwired to zero, optional write-to-read bypass, and a per-register
//  busy scoreboard for issue-stage RAW hazard checks.
//  Sits between decode/issue (read + allocate) and writeback (write/release).
//  Lane i owns write port i, allocate port i and read ports 2i and 2i+1.
// PARAMETERS
//  XLEN    64  data width in bits
//  NREG    32  number of architectural registers; power of two, >= 2
//  NWR     2   write ports, which is also the number of lanes and allocate ports
//  NRD     4   read ports; must equal 2*NWR
//  BYPASS  1   1: a read returns same-cycle write data; 0: a read returns stored value only
//  AW is a localparam equal to $clog2(NREG). Port i occupies bits [i*W +: W] of each flat bus.
// PORTS
//  clk         in   1         clock; all state updates on the rising edge
//  rst_n       in   1         asynchronous active-low reset
//  wen         in   NWR       write enable per port
//  wr_addr     in   NWR*AW    destination register per write port
//  wr_data     in   NWR*XLEN  write data per write port
//  alloc_en    in   NWR       mark a destination busy; the issuing instruction is its producer
//  alloc_addr  in   NWR*AW    register to mark busy
//  rd_addr     in   NRD*AW    source register per read port
//  rd_data     out  NRD*XLEN  read data per read port (combinational)
//  rd_busy     out  NRD       1 = source has an outstanding producer (combinational)
// BEHAVIOUR
//  Reset
//   - rst_n low sets every register to 0 and clears every busy bit, immediately.
//   - While in reset: rd_data = 0 and rd_busy = 0 on all ports.
//   - An asserted rst_n overrides any write or allocate in the same cycle.
//  Write
//   - Latency 1: at posedge clk, reg[wr_addr[i]] <= wr_data[i] when wen[i]=1 and wr_addr[i]!=0.
//   - Writes to x0 are discarded. x0 reads 0 and is never busy.
//   - Two or more ports writing the same address: the highest-index port wins (youngest lane).
//   - Different addresses: all ports write in the same cycle.
//  Read (combinational, no clock)
//   - rd_addr=0 returns 0.
//   - BYPASS=1 and some wen[i] with wr_addr[i]==rd_addr!=0: return wr_data of the
//     highest-index matching port.
//   - Otherwise (and always when BYPASS=0): return the stored register value.
//  Scoreboard
//   - Each register has one busy bit.
//   - At posedge clk, alloc_en[i] with alloc_addr[i]!=0 sets the bit.
//   - At posedge clk, wen[i] with wr_addr[i]!=0 clears the bit.
//   - Same register allocated and written in the same cycle: the allocate wins and the
//     bit stays 1, because the allocation is a newer producer.
//   - rd_busy[j] = busy[rd_addr[j]] & (rd_addr[j]!=0).
//   - When BYPASS=1, rd_busy[j] is forced to 0 if a same-cycle write hits rd_addr[j] and no
//     allocate hits that register in the same cycle.
//   - Multiple allocates to the same register, or re-allocating a busy register: legal;
//     the bit stays 1.
//  Data is stored as unsigned bit vectors; signedness belongs to the consumer.
// TESTING
//  1. Pulse rst_n low mid-run after writes -> all rd_data=0 and rd_busy=0 immediately,
//     with no clock edge needed.
//  2. wen=2'b11, addr 5 / 9, data 64'hA / 64'hB -> next cycle reg5=A and reg9=B.
//  3. wen=2'b11, both to addr 7, data 1 / 2 -> reg7=2 (port 1 wins).
//  4. wen[0] to x0 with 64'hFFFF -> rd_addr=0 reads 0. BYPASS=1 same-cycle read of x0 also 0.
//  5. BYPASS=1: write reg3=64'h55 while reading 3 -> rd_data=64'h55 in the same cycle.
//     Repeat with BYPASS=0 -> old value this cycle, 64'h55 on the next cycle.
//  6. alloc reg12 -> rd_busy=1 next cycle. Write reg12 and alloc reg12 in one cycle ->
//     still busy. A later write alone -> busy clears.

Source files
------------

// File: rtl/superscalar_regfile_sb.sv
// superscalar_regfile_sb
//   Multi-port integer register file for the N-way superscalar core with a
//   per-register busy scoreboard. x0 reads zero and is never busy. Lane i owns
//   write port i, allocate port i and read ports 2i / 2i+1.
// Ports
//   clk, rst_n          clock, async active-low reset
//   wen/wr_addr/wr_data write ports (flat, port i at [i*W +: W])
//   alloc_en/alloc_addr mark destination busy at issue
//   rd_addr             read port addresses
//   rd_data/rd_busy     combinational read data and busy flag per read port

// One read port: bypass select, storage read and busy qualification.
module superscalar_regfile_sb_rdport #(
   parameter int XLEN   = 64,
   parameter int NREG   = 32,
   parameter int NWR    = 2,
   parameter int BYPASS = 1,
   parameter int AW     = 5
) (
   input  logic                           rst_n,
   input  logic [NREG-1:0][XLEN-1:0]      regs,
   input  logic [NREG-1:0]                busy,
   input  logic [NWR-1:0]                 wen,
   input  logic [NWR-1:0][AW-1:0]         wa,
   input  logic [NWR-1:0][XLEN-1:0]       wd,
   input  logic [NWR-1:0]                 alloc_en,
   input  logic [NWR-1:0][AW-1:0]         aa,
   input  logic [AW-1:0]                  rd_addr,
   output logic [XLEN-1:0]                rd_data,
   output logic                           rd_busy
);
   logic            hit;
   logic            ahit;
   logic [XLEN-1:0] hdata;

   always_comb begin
      hit   = 1'b0;
      ahit  = 1'b0;
      hdata = '0;
      // ascending scan: the highest-index matching write port is left in hdata
      for (int i = 0; i < NWR; i++) begin
         if (wen[i] && wa[i] == rd_addr) begin
            hit   = 1'b1;
            hdata = wd[i];
         end
         if (alloc_en[i] && aa[i] == rd_addr) ahit = 1'b1;
      end
      if (!rst_n || rd_addr == '0) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end else if (BYPASS != 0 && hit) begin
         rd_data = hdata;
         // the in-flight write retires the producer unless a newer one is
         // being allocated this same cycle
         rd_busy = ahit & busy[rd_addr];
      end else begin
         rd_data = regs[rd_addr];
         rd_busy = busy[rd_addr];
      end
   end
endmodule

module superscalar_regfile_sb #(
   parameter int XLEN   = 64,
   parameter int NREG   = 32,
   parameter int NWR    = 2,
   parameter int NRD    = 4,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NWR-1:0]        wen,
   input  logic [NWR*AW-1:0]     wr_addr,
   input  logic [NWR*XLEN-1:0]   wr_data,
   input  logic [NWR-1:0]        alloc_en,
   input  logic [NWR*AW-1:0]     alloc_addr,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*XLEN-1:0]   rd_data,
   output logic [NRD-1:0]        rd_busy
);
   logic [NWR-1:0][AW-1:0]   wa;
   logic [NWR-1:0][XLEN-1:0] wd;
   logic [NWR-1:0][AW-1:0]   aa;
   logic [NRD-1:0][AW-1:0]   ra;
   logic [NRD-1:0][XLEN-1:0] rdat;

   assign wa      = wr_addr;
   assign wd      = wr_data;
   assign aa      = alloc_addr;
   assign ra      = rd_addr;
   assign rd_data = rdat;

   logic [NREG-1:0][XLEN-1:0] regs;
   logic [NREG-1:0]           busy;

   // Later loop iterations override earlier ones, so the youngest lane wins
   // on address collisions, and allocate (second loop) wins over release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
         busy <= '0;
      end else begin
         for (int i = 0; i < NWR; i++) begin
            if (wen[i] && wa[i] != '0) begin
               regs[wa[i]] <= wd[i];
               busy[wa[i]] <= 1'b0;
            end
         end
         for (int i = 0; i < NWR; i++) begin
            if (alloc_en[i] && aa[i] != '0) busy[aa[i]] <= 1'b1;
         end
      end
   end

   for (genvar j = 0; j < NRD; j++) begin : g_rd
      superscalar_regfile_sb_rdport #(
         .XLEN(XLEN), .NREG(NREG), .NWR(NWR), .BYPASS(BYPASS), .AW(AW)
      ) u_rd (
         .rst_n    (rst_n),
         .regs     (regs),
         .busy     (busy),
         .wen      (wen),
         .wa       (wa),
         .wd       (wd),
         .alloc_en (alloc_en),
         .aa       (aa),
         .rd_addr  (ra[j]),
         .rd_data  (rdat[j]),
         .rd_busy  (rd_busy[j])
      );
   end
endmodule

// File: tb/tb_superscalar_regfile_sb.sv
module tb_superscalar_regfile_sb;
   localparam int XLEN = 64, NREG = 32, NWR = 2, NRD = 4, AW = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic [NWR-1:0]      wen;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NWR-1:0]      alloc_en;
   logic [NWR*AW-1:0]   alloc_addr;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data1, rd_data0;
   logic [NRD-1:0]      rd_busy1, rd_busy0;

   always #5 clk = ~clk;

   superscalar_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NWR(NWR), .NRD(NRD), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .rd_addr(rd_addr),
      .rd_data(rd_data1), .rd_busy(rd_busy1));

   superscalar_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NWR(NWR), .NRD(NRD), .BYPASS(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .rd_addr(rd_addr),
      .rd_data(rd_data0), .rd_busy(rd_busy0));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      string       tag;
      int          port;
      bit          byp;
      logic [63:0] data;
      logic        busy;
   } exp_t;
   exp_t sbq[$];

   task automatic push(input string tag, input int port, input bit byp,
                       input logic [63:0] d, input logic b);
      exp_t e;
      e.tag = tag; e.port = port; e.byp = byp; e.data = d; e.busy = b;
      sbq.push_back(e);
   endtask

   task automatic both(input string tag, input int port, input logic [63:0] d, input logic b);
      push(tag, port, 1'b1, d, b);
      push(tag, port, 1'b0, d, b);
   endtask

   task automatic check_all();
      exp_t e;
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.byp) begin
            chk({e.tag, "_byp_d"}, rd_data1[e.port*XLEN +: XLEN], e.data);
            chk({e.tag, "_byp_b"}, {63'b0, rd_busy1[e.port]}, {63'b0, e.busy});
         end else begin
            chk({e.tag, "_nob_d"}, rd_data0[e.port*XLEN +: XLEN], e.data);
            chk({e.tag, "_nob_b"}, {63'b0, rd_busy0[e.port]}, {63'b0, e.busy});
         end
      end
   endtask

   task automatic idle();
      wen = '0;
      alloc_en = '0;
   endtask

   task automatic wr(input int i, input logic [AW-1:0] a, input logic [63:0] d);
      wen[i] = 1'b1;
      wr_addr[i*AW +: AW] = a;
      wr_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic alloc(input int i, input logic [AW-1:0] a);
      alloc_en[i] = 1'b1;
      alloc_addr[i*AW +: AW] = a;
   endtask

   task automatic setrd(input int j, input logic [AW-1:0] a);
      rd_addr[j*AW +: AW] = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference state for the randomized phase
   logic [63:0] mreg [NREG];
   logic        mbusy[NREG];

   task automatic exp_rd(input logic [AW-1:0] a, input bit byp,
                         output logic [63:0] d, output logic b);
      logic        hit, ahit;
      logic [63:0] hd;
      hit = 0; ahit = 0; hd = '0;
      for (int i = 0; i < NWR; i++) begin
         if (wen[i] && wr_addr[i*AW +: AW] == a) begin
            hit = 1; hd = wr_data[i*XLEN +: XLEN];
         end
         if (alloc_en[i] && alloc_addr[i*AW +: AW] == a) ahit = 1;
      end
      if (a == 0) begin
         d = '0; b = 1'b0;
      end else begin
         d = (byp && hit) ? hd : mreg[a];
         b = mbusy[a] && !(byp && hit && !ahit);
      end
   endtask

   task automatic model_update();
      logic [AW-1:0] a;
      for (int i = 0; i < NWR; i++) begin
         a = wr_addr[i*AW +: AW];
         if (wen[i] && a != 0) begin
            mreg[a] = wr_data[i*XLEN +: XLEN];
            mbusy[a] = 1'b0;
         end
      end
      for (int i = 0; i < NWR; i++) begin
         a = alloc_addr[i*AW +: AW];
         if (alloc_en[i] && a != 0) mbusy[a] = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] d;
      logic        b;
      rst_n = 1'b0;
      idle();
      wr_addr = '0; wr_data = '0; alloc_addr = '0; rd_addr = '0;
      for (int r = 0; r < NREG; r++) begin mreg[r] = '0; mbusy[r] = 1'b0; end

      // in reset: write/alloc activity and bypass must not show through
      #2;
      setrd(0, 5); setrd(1, 9); setrd(2, 7); setrd(3, 12);
      wr(0, 5, 64'hA); alloc(1, 12);
      for (int j = 0; j < NRD; j++) both("rst", j, 64'h0, 1'b0);
      check_all();
      tick();
      idle();
      rst_n = 1'b1;
      for (int j = 0; j < NRD; j++) both("rst_ovr", j, 64'h0, 1'b0);
      check_all();

      // two ports, different addresses
      wr(0, 5, 64'hA); wr(1, 9, 64'hB);
      push("w2_same", 0, 1'b1, 64'hA, 1'b0); push("w2_same", 1, 1'b1, 64'hB, 1'b0);
      push("w2_same", 0, 1'b0, 64'h0, 1'b0); push("w2_same", 1, 1'b0, 64'h0, 1'b0);
      check_all();
      tick(); idle();
      both("w2_next5", 0, 64'hA, 1'b0); both("w2_next9", 1, 64'hB, 1'b0);
      check_all();

      // collision: port 1 wins
      wr(0, 7, 64'h1); wr(1, 7, 64'h2);
      push("coll_same", 2, 1'b1, 64'h2, 1'b0); push("coll_same", 2, 1'b0, 64'h0, 1'b0);
      check_all();
      tick(); idle();
      both("coll_next", 2, 64'h2, 1'b0);
      check_all();

      // x0 discards writes and never goes busy
      wr(0, 0, 64'hFFFF); alloc(1, 0); setrd(3, 0);
      both("x0_same", 3, 64'h0, 1'b0);
      check_all();
      tick(); idle();
      both("x0_next", 3, 64'h0, 1'b0);
      check_all();

      // bypass vs stored value
      wr(0, 3, 64'h11); tick(); idle();
      wr(0, 3, 64'h55); setrd(1, 3);
      push("byp_same", 1, 1'b1, 64'h55, 1'b0); push("byp_same", 1, 1'b0, 64'h11, 1'b0);
      check_all();
      tick(); idle();
      both("byp_next", 1, 64'h55, 1'b0);
      check_all();

      // scoreboard
      setrd(0, 12); alloc(0, 12);
      both("sb_alloc_same", 0, 64'h0, 1'b0);
      check_all();
      tick(); idle();
      both("sb_alloc_next", 0, 64'h0, 1'b1);
      check_all();
      wr(1, 12, 64'h77); alloc(0, 12);
      push("sb_wa_same", 0, 1'b1, 64'h77, 1'b1); push("sb_wa_same", 0, 1'b0, 64'h0, 1'b1);
      check_all();
      tick(); idle();
      both("sb_wa_next", 0, 64'h77, 1'b1);
      check_all();
      alloc(0, 12); alloc(1, 12);
      tick(); idle();
      both("sb_dbl", 0, 64'h77, 1'b1);
      check_all();
      wr(0, 12, 64'h88);
      push("sb_rel_same", 0, 1'b1, 64'h88, 1'b0); push("sb_rel_same", 0, 1'b0, 64'h77, 1'b1);
      check_all();
      tick(); idle();
      both("sb_rel_next", 0, 64'h88, 1'b0);
      check_all();

      // mid-run async reset, no clock edge in between
      alloc(0, 12); tick(); idle();
      setrd(0, 5); setrd(1, 9); setrd(2, 7); setrd(3, 12);
      both("pre_rst5", 0, 64'hA, 1'b0); both("pre_rst9", 1, 64'hB, 1'b0);
      both("pre_rst7", 2, 64'h2, 1'b0); both("pre_rst12", 3, 64'h88, 1'b1);
      check_all();
      wr(0, 5, 64'h123);
      #2;
      rst_n = 1'b0;
      for (int j = 0; j < NRD; j++) both("async_rst", j, 64'h0, 1'b0);
      check_all();
      idle();
      tick();
      rst_n = 1'b1;
      for (int j = 0; j < NRD; j++) both("post_rst", j, 64'h0, 1'b0);
      check_all();

      // randomized traffic over a small address window to force collisions
      for (int c = 0; c < 60; c++) begin
         idle();
         for (int i = 0; i < NWR; i++) begin
            if ($urandom_range(1, 0) == 1)
               wr(i, AW'($urandom_range(7, 0)), {$urandom(), $urandom()});
            if ($urandom_range(2, 0) == 0)
               alloc(i, AW'($urandom_range(7, 0)));
         end
         for (int j = 0; j < NRD; j++) setrd(j, AW'($urandom_range(7, 0)));
         for (int j = 0; j < NRD; j++) begin
            exp_rd(rd_addr[j*AW +: AW], 1'b1, d, b); push("rnd", j, 1'b1, d, b);
            exp_rd(rd_addr[j*AW +: AW], 1'b0, d, b); push("rnd", j, 1'b0, d, b);
         end
         check_all();
         model_update();
         tick();
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
